// File: rtl/io_packet_encoder.sv
// ----------------------------------------------------------------------------
// io_packet_encoder
//
// Host-side transmitter for the accelerator load path. One Start produces one
// packet. The block raises a one-cycle INT (with Load_Process=1) so the
// accelerator prepares to receive. It then sends a header beat followed by
// two 32-bit beats per 64-bit staging-RAM word, low half first.
//
// Ports
//   CLK               in   rising-edge clock
//   RST               in   asynchronous reset, active low
//   Start             in   one-cycle packet request, honoured only when idle
//   Src_Base_Address  in   first staging-RAM word of the packet
//   Dest_Base_Address in   accelerator RAM address carried in the header
//   Word_Count        in   number of 64-bit words N (0..32767)
//   Last_Packet       in   header flag marking the final packet of a load
//   Mem_Data_RD       in   staging-RAM read data, one cycle after the address
//   Mem_Address_RD    out  staging-RAM read address
//   CPU_Bus           out  bus beat, zero whenever Bus_Valid is low
//   Bus_Valid         out  beat on CPU_Bus is valid
//   Bus_Ready         in   receiver takes the beat on Valid && Ready at posedge
//   INT               out  one-cycle interrupt pulse at packet start
//   Load_Process      out  load-direction flag, high only together with INT
//   Busy              out  high in every state except idle
//   Done              out  one-cycle pulse after the last beat is accepted
//
// Every output is a flop. Each one is loaded from the decoded next state, so
// its value always lines up with the state the machine has just entered.
// ----------------------------------------------------------------------------
module io_packet_encoder #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [ADDRESS_WIDTH-1:0] Src_Base_Address,
    input  logic [ADDRESS_WIDTH-1:0] Dest_Base_Address,
    input  logic [14:0]              Word_Count,
    input  logic                     Last_Packet,
    input  logic [DATA_WIDTH-1:0]    Mem_Data_RD,
    output logic [ADDRESS_WIDTH-1:0] Mem_Address_RD,
    output logic [31:0]              CPU_Bus,
    output logic                     Bus_Valid,
    input  logic                     Bus_Ready,
    output logic                     INT,
    output logic                     Load_Process,
    output logic                     Busy,
    output logic                     Done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INT    = 3'd1;
    localparam logic [2:0] ST_HEADER = 3'd2;
    localparam logic [2:0] ST_FETCH  = 3'd3;
    localparam logic [2:0] ST_LOAD   = 3'd4;
    localparam logic [2:0] ST_LOW    = 3'd5;
    localparam logic [2:0] ST_HIGH   = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    // Header layout: {last flag, 15-bit word count, destination zero-extended to 16}.
    function automatic logic [31:0] header_beat(
        input logic                     last_flag,
        input logic [14:0]              word_cnt,
        input logic [ADDRESS_WIDTH-1:0] dest_addr
    );
        logic [15:0] dest_ext;
        dest_ext = 16'(dest_addr);
        return {last_flag, word_cnt, dest_ext};
    endfunction

    logic [2:0]               state_r;
    logic [ADDRESS_WIDTH-1:0] src_r;
    logic [ADDRESS_WIDTH-1:0] dest_r;
    logic [14:0]              count_r;
    logic                     last_r;
    logic [14:0]              idx_r;
    logic [DATA_WIDTH-1:0]    word_r;

    logic [2:0]               state_next_s;
    logic [14:0]              idx_next_s;
    logic [DATA_WIDTH-1:0]    word_next_s;
    logic [31:0]              bus_next_s;
    logic [ADDRESS_WIDTH-1:0] addr_next_s;
    logic                     accept_s;
    logic                     beat_next_s;

    // A beat is taken only while this block is actually presenting one.
    assign accept_s = Bus_Valid & Bus_Ready;

    // Next-state and word-index decode.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_next_s = ST_INT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INT: begin
                state_next_s = ST_HEADER;
            end
            ST_HEADER: begin
                if (accept_s) begin
                    if (count_r == 15'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_HEADER;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_LOAD;
            end
            ST_LOAD: begin
                state_next_s = ST_LOW;
            end
            ST_LOW: begin
                if (accept_s) begin
                    state_next_s = ST_HIGH;
                end else begin
                    state_next_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (accept_s) begin
                    // The index counts completed words. Reaching N ends the packet.
                    idx_next_s = idx_r + 15'd1;
                    if (idx_next_s == count_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_HIGH;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Data-path decode: word capture, next bus beat, next read address.
    always_comb begin
        // The RAM answers one cycle after FETCH, so LOAD sees the requested word.
        if (state_r == ST_LOAD) begin
            word_next_s = Mem_Data_RD;
        end else begin
            word_next_s = word_r;
        end

        // Address arithmetic wraps modulo 2^ADDRESS_WIDTH by truncation.
        addr_next_s = src_r + ADDRESS_WIDTH'(idx_next_s);

        case (state_next_s)
            ST_HEADER: begin
                bus_next_s  = header_beat(last_r, count_r, dest_r);
                beat_next_s = 1'b1;
            end
            ST_LOW: begin
                bus_next_s  = word_next_s[31:0];
                beat_next_s = 1'b1;
            end
            ST_HIGH: begin
                bus_next_s  = word_next_s[DATA_WIDTH-1 -: 32];
                beat_next_s = 1'b1;
            end
            default: begin
                bus_next_s  = 32'd0;
                beat_next_s = 1'b0;
            end
        endcase
    end

    // State, latched operands, word index and word register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            src_r   <= '0;
            dest_r  <= '0;
            count_r <= 15'd0;
            last_r  <= 1'b0;
            idx_r   <= 15'd0;
            word_r  <= '0;
        end else begin
            state_r <= state_next_s;
            word_r  <= word_next_s;
            if ((state_r == ST_IDLE) && Start) begin
                src_r   <= Src_Base_Address;
                dest_r  <= Dest_Base_Address;
                count_r <= Word_Count;
                last_r  <= Last_Packet;
                idx_r   <= 15'd0;
            end else begin
                idx_r   <= idx_next_s;
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Mem_Address_RD <= '0;
            CPU_Bus        <= 32'd0;
            Bus_Valid      <= 1'b0;
            INT            <= 1'b0;
            Load_Process   <= 1'b0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
        end else begin
            CPU_Bus      <= bus_next_s;
            Bus_Valid    <= beat_next_s;
            INT          <= (state_next_s == ST_INT);
            Load_Process <= (state_next_s == ST_INT);
            Busy         <= (state_next_s != ST_IDLE);
            Done         <= (state_next_s == ST_DONE);
            // The address is only meaningful in FETCH. It holds at all other times.
            if (state_next_s == ST_FETCH) begin
                Mem_Address_RD <= addr_next_s;
            end else begin
                Mem_Address_RD <= Mem_Address_RD;
            end
        end
    end

endmodule

// File: tb/tb_io_packet_encoder.sv
// ----------------------------------------------------------------------------
// tb_io_packet_encoder
//
// Directed bench for io_packet_encoder. For each Start, a packet model builds
// the full list of expected beats from the operands and a staging-RAM array.
// A negedge monitor checks every accepted beat against that list. It also
// checks the bus rules: bus is zero when not valid, a beat is held until
// accepted, Load_Process tracks INT, and Busy spans from INT through Done.
// Hand-computed literals pin the header layout and the cycle timing.
// ----------------------------------------------------------------------------
module tb_io_packet_encoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Start = 1'b0;
    logic [12:0] src = 13'd0;
    logic [12:0] dest = 13'd0;
    logic [14:0] wc = 15'd0;
    logic        last = 1'b0;
    logic [63:0] mem_rd = 64'd0;
    logic [12:0] mem_addr;
    logic [31:0] cpu_bus;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        irq;
    logic        lp;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_int = 0;
    int n_done = 0;

    logic [63:0] ram [0:8191];
    logic [31:0] exp_q[$];
    logic [12:0] addr_log[$];
    logic [12:0] last_addr = 13'd0;
    bit          in_pkt = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_bus = 32'd0;
    bit          rdy_rand = 1'b0;
    bit          rdy_level = 1'b0;

    io_packet_encoder #(.ADDRESS_WIDTH(13), .DATA_WIDTH(64)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .Start             (Start),
        .Src_Base_Address  (src),
        .Dest_Base_Address (dest),
        .Word_Count        (wc),
        .Last_Packet       (last),
        .Mem_Data_RD       (mem_rd),
        .Mem_Address_RD    (mem_addr),
        .CPU_Bus           (cpu_bus),
        .Bus_Valid         (bus_valid),
        .Bus_Ready         (bus_ready),
        .INT               (irq),
        .Load_Process      (lp),
        .Busy              (busy),
        .Done              (done)
    );

    always #5 CLK = ~CLK;

    // Staging RAM with one cycle of synchronous read latency.
    always @(posedge CLK) mem_rd <= ram[mem_addr];

    // Receiver ready: either held at a level or toggling randomly.
    always @(posedge CLK) begin
        #1;
        if (rdy_rand) bus_ready = 1'($urandom_range(0, 1));
        else          bus_ready = rdy_level;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Packet model: the header followed by low/high halves of N RAM words.
    task automatic start_pkt(input logic [12:0] s, input logic [12:0] d,
                             input logic [14:0] n, input logic l);
        logic [31:0] hdr;
        logic [63:0] w;
        hdr = (32'(l) << 31) | (32'(n) << 16) | 32'(d);
        exp_q.push_back(hdr);
        for (int i = 0; i < int'(n); i++) begin
            w = ram[(int'(s) + i) % 8192];
            exp_q.push_back(w[31:0]);
            exp_q.push_back(w[63:32]);
        end
        src = s; dest = d; wc = n; last = l; Start = 1'b1;
        tick();
        Start = 1'b0;
        // Change the inputs afterwards to show that the DUT uses its latched copy.
        src = 13'h0BAD; dest = 13'h0F0F; wc = 15'd77; last = ~l;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_addr"},  64'(mem_addr),  64'd0);
        chk({name, "_bus"},   64'(cpu_bus),   64'd0);
        chk({name, "_valid"}, 64'(bus_valid), 64'd0);
        chk({name, "_int"},   64'(irq),       64'd0);
        chk({name, "_lp"},    64'(lp),        64'd0);
        chk({name, "_busy"},  64'(busy),      64'd0);
        chk({name, "_done"},  64'(done),      64'd0);
    endtask

    // Per-cycle monitor: bus rules, beat values against the model, and Busy span.
    always @(negedge CLK) begin
        if (!RST) begin
            exp_q.delete();
            prev_hold = 1'b0;
            in_pkt = 1'b0;
            last_addr = mem_addr;
        end else begin
            if (mem_addr !== last_addr) addr_log.push_back(mem_addr);
            last_addr = mem_addr;
            chk("int_vs_load_process", 64'(lp), 64'(irq));
            chk("busy_span", 64'(busy), 64'(irq | in_pkt));
            if (!bus_valid) chk("bus_zero_when_idle", 64'(cpu_bus), 64'd0);
            if (prev_hold) begin
                chk("valid_held", 64'(bus_valid), 64'd1);
                chk("bus_stable", 64'(cpu_bus), 64'(prev_bus));
            end
            if (bus_valid && bus_ready) begin
                n_acc++;
                chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) chk("beat_value", 64'(cpu_bus), 64'(exp_q.pop_front()));
            end
            if (done) begin
                chk("done_all_beats_sent", 64'(exp_q.size()), 64'd0);
                n_done++;
                in_pkt = 1'b0;
            end
            if (irq) begin
                in_pkt = 1'b1;
                n_int++;
            end
            prev_hold = bus_valid && !bus_ready;
            prev_bus = cpu_bus;
        end
    end

    initial begin
        int acc0, int0;
        for (int i = 0; i < 8192; i++) begin
            ram[i] = {16'hC0DE, 3'b000, i[12:0], 16'h5A5A, 3'b000, i[12:0]};
        end
        ram[13'h0010] = 64'hDEADBEEF_01234567;
        ram[13'h1FFF] = 64'h11112222_33334444;
        ram[13'h0000] = 64'h55556666_77778888;

        // 1: reset with Start held high.
        Start = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        Start = 1'b0;
        RST = 1'b1;
        repeat (3) begin
            tick();
            chk("no_int_after_reset", 64'(irq), 64'd0);
            chk("idle_after_reset", 64'(busy), 64'd0);
        end

        // 2: one word, Ready held high, exact cycle timing.
        rdy_level = 1'b1;
        tick();
        start_pkt(13'h010, 13'h020, 15'd1, 1'b0);
        chk("t2_int", 64'(irq), 64'd1);
        chk("t2_lp", 64'(lp), 64'd1);
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_no_valid_in_int", 64'(bus_valid), 64'd0);
        tick();
        chk("t2_int_one_cycle", 64'(irq), 64'd0);
        chk("t2_hdr_valid", 64'(bus_valid), 64'd1);
        chk("t2_hdr", 64'(cpu_bus), 64'h00010020);
        tick();
        chk("t2_fetch_addr", 64'(mem_addr), 64'h010);
        tick();
        tick();
        chk("t2_low", 64'(cpu_bus), 64'h01234567);
        tick();
        chk("t2_high", 64'(cpu_bus), 64'hDEADBEEF);
        tick();
        chk("t2_done", 64'(done), 64'd1);
        Start = 1'b1;                       // Start while in DONE must be ignored
        tick();
        Start = 1'b0;
        chk("t2_done_pulse", 64'(done), 64'd0);
        chk("t2_idle", 64'(busy), 64'd0);
        tick();
        chk("t2_start_in_done_ignored", 64'(irq), 64'd0);

        // 3: zero-length last packet, no RAM read.
        addr_log.delete();
        start_pkt(13'h0AA, 13'h1ABC, 15'd0, 1'b1);
        tick();
        chk("t3_hdr", 64'(cpu_bus), 64'h80001ABC);
        tick();
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_no_read", 64'(addr_log.size()), 64'd0);
        repeat (2) tick();

        // 4: three words, random Ready, spurious Start mid-packet.
        acc0 = n_acc; int0 = n_int;
        rdy_rand = 1'b1;
        start_pkt(13'h100, 13'h0333, 15'd3, 1'b0);
        repeat (5) tick();
        src = 13'h0222; dest = 13'h0444; wc = 15'd9; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(400, "t4_done_timeout");
        rdy_rand = 1'b0;
        repeat (3) tick();
        chk("t4_beats", 64'(n_acc - acc0), 64'd7);
        chk("t4_one_int", 64'(n_int - int0), 64'd1);
        chk("t4_idle", 64'(busy), 64'd0);

        // 5: address wrap.
        addr_log.delete();
        start_pkt(13'h1FFF, 13'h0001, 15'd2, 1'b0);
        wait_done(100, "t5_done_timeout");
        chk("t5_reads", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) begin
            chk("t5_addr0", 64'(addr_log[0]), 64'h1FFF);
            chk("t5_addr1", 64'(addr_log[1]), 64'h0000);
        end
        repeat (2) tick();

        // 6: reset during LOW of the second word of a four-word packet.
        acc0 = n_acc;
        start_pkt(13'h200, 13'h0055, 15'd4, 1'b0);
        for (int k = 0; k < 50 && (n_acc - acc0) < 3; k++) tick();
        rdy_level = 1'b0;
        for (int k = 0; k < 20 && !bus_valid; k++) tick();
        chk("t6_in_low", 64'(cpu_bus), 64'(ram[13'h201][31:0]));
        RST = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        repeat (2) tick();
        RST = 1'b1;
        rdy_level = 1'b1;
        repeat (2) tick();
        chk("t6_stays_idle", 64'(busy), 64'd0);
        acc0 = n_acc; int0 = n_int;
        start_pkt(13'h300, 13'h0777, 15'd2, 1'b1);
        wait_done(100, "t6_done_timeout");
        repeat (2) tick();
        chk("t6_beats", 64'(n_acc - acc0), 64'd5);
        chk("t6_one_int", 64'(n_int - int0), 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
